// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: issues one memory request at a time for the
// current fetch PC, returns the fetched word (or a NOP on redirect) to the
// fetch stage with a single-cycle update pulse, and parks a response in a
// one-entry buffer while the backend is stalled.
module ifu_fetch_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic [63:0] pc,
    input  logic        jump_en,
    input  logic        be_stall,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instr,
    output logic        update,
    output logic        busy,
    output logic [63:0] fetch_cnt
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam logic [ILEN-1:0] NOP = ILEN'(32'h0000_0013);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ILEN-1:0]   buf_q;
    logic [ILEN-1:0]   buf_d;
    logic [XLEN-1:0]   fetch_cnt_q;
    logic [XLEN-1:0]   fetch_cnt_d;

    // State register; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a redirect always wins over a backend stall.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (!jump_en && imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    if (!jump_en && be_stall) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else if (jump_en) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (jump_en || !be_stall) begin
                    state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs and datapath next values; request/update follow inputs in the same cycle.
    always_comb begin
        imem_req_valid = 1'b0;
        update         = 1'b0;
        instr          = NOP;
        busy           = 1'b0;
        buf_d          = buf_q;
        fetch_cnt_d    = fetch_cnt_q;
        case (state_q)
            ST_REQ: begin
                imem_req_valid = !jump_en;
                update         = jump_en;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (jump_en) begin
                    update = 1'b1;
                end else if (imem_rsp_valid) begin
                    if (be_stall) begin
                        buf_d = imem_rsp_data;
                    end else begin
                        update      = 1'b1;
                        instr       = imem_rsp_data;
                        fetch_cnt_d = fetch_cnt_q + XLEN'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (jump_en) begin
                    update = 1'b1;
                end else if (!be_stall) begin
                    update      = 1'b1;
                    instr       = buf_q;
                    fetch_cnt_d = fetch_cnt_q + XLEN'(1);
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Response buffer and delivered-instruction counter (counter wraps freely).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            buf_q       <= '0;
            fetch_cnt_q <= '0;
        end else begin
            buf_q       <= buf_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign imem_req_addr = pc;
    assign fetch_cnt     = fetch_cnt_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Testbench for ifu_fetch_ctrl: directed per-cycle vectors drive the control
// inputs, a small latency-programmable memory answers handshakes, and a
// monitor pops expected deliveries from a scoreboard whenever update is high.
module tb_ifu_fetch_ctrl;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [63:0] pc;
    logic        jump_en;
    logic        be_stall;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr;
    logic        update;
    logic        busy;
    logic [63:0] fetch_cnt;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc_no  = 0;
    bit          mon_on  = 1'b0;

    int          mem_lat   = 1;
    logic [31:0] mem_word  = 32'h0000_0093;
    int          pend      = 0;
    logic [31:0] pend_word = 32'h0;

    ifu_fetch_ctrl dut (
        .clk            (clk),
        .rstn           (rstn),
        .pc             (pc),
        .jump_en        (jump_en),
        .be_stall       (be_stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr          (instr),
        .update         (update),
        .busy           (busy),
        .fetch_cnt      (fetch_cnt)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL c%0d %s: got %h, expected %h", cyc_no, name, act, exp);
        end
    endtask

    // One cycle: drive inputs at negedge, check outputs 1ns later.
    task automatic cyc(input logic r, input logic rdy, input logic stl, input logic jmp,
                       input logic eu, input logic eb, input logic ev);
        @(negedge clk);
        rstn           = r;
        imem_req_ready = rdy;
        be_stall       = stl;
        jump_en        = jmp;
        pc             = pc + 64'd4;
        cyc_no++;
        #1;
        chk("update", 64'(update), 64'(eu));
        chk("busy", 64'(busy), 64'(eb));
        chk("imem_req_valid", 64'(imem_req_valid), 64'(ev));
        chk("imem_req_addr", imem_req_addr, pc);
    endtask

    task automatic push(input logic [31:0] i, input logic [63:0] c);
        exp_t e;
        e.instr = i;
        e.cnt   = c;
        sb.push_back(e);
    endtask

    // Memory: one response mem_lat cycles after each accepted request.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hBAD0_0BAD;
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = pend_word;
                end
            end
            #2;
            if (imem_req_valid && imem_req_ready) begin
                pend      = mem_lat;
                pend_word = mem_word;
            end
        end
    end

    // Monitor: compare every update against the scoreboard, count one cycle later.
    initial begin
        bit          cnt_chk;
        logic [63:0] cnt_exp;
        bit          prev_upd;
        exp_t        e;
        cnt_chk  = 1'b0;
        cnt_exp  = '0;
        prev_upd = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (mon_on) begin
                if (cnt_chk) begin
                    chk("sb fetch_cnt", fetch_cnt, cnt_exp);
                    cnt_chk = 1'b0;
                end
                if (update) begin
                    chk("update back-to-back", 64'(prev_upd), 64'(0));
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL c%0d sb unexpected update: instr %h, none expected", cyc_no, instr);
                    end else begin
                        e = sb.pop_front();
                        chk("sb instr", 64'(instr), 64'(e.instr));
                        cnt_chk = 1'b1;
                        cnt_exp = e.cnt;
                    end
                end else begin
                    chk("instr when no update", 64'(instr), 64'(NOP));
                end
                prev_upd = update;
            end
        end
    end

    initial begin
        rstn           = 1'b0;
        pc             = 64'h0000_0000_8000_0000;
        jump_en        = 1'b0;
        be_stall       = 1'b0;
        imem_req_ready = 1'b0;

        // Reset held: IDLE outputs, cleared counter
        repeat (3) @(negedge clk);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("reset fetch_cnt", fetch_cnt, 64'd0);
        chk("reset instr", 64'(instr), 64'(NOP));
        mon_on = 1'b1;

        // Zero-wait streaming: IDLE once, then update every other cycle
        push(32'h0000_0093, 64'd1);
        push(32'h0000_0093, 64'd2);
        push(32'h0000_0093, 64'd3);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 1, 1, 0);
        cyc(1, 1, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 1, 1, 0);
        cyc(1, 1, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);

        // Backend stall for 3 cycles: buffered word delivered on release
        mem_word = 32'hDEAD_BEEF;
        push(32'hDEAD_BEEF, 64'd4);
        cyc(1, 1, 1, 0, 0, 0, 1);
        cyc(1, 0, 1, 0, 0, 1, 0);
        cyc(1, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);

        // Redirect in HOLD beats the stall; buffer discarded
        mem_word = 32'h1111_1111;
        push(NOP, 64'd4);
        cyc(1, 1, 1, 0, 0, 0, 1);
        cyc(1, 0, 1, 0, 0, 1, 0);
        cyc(1, 0, 1, 1, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);

        // Redirect in WAIT with slow memory: DRAIN, then redirect in REQ with ready=1
        mem_lat  = 4;
        mem_word = 32'h2222_2222;
        push(NOP, 64'd4);
        push(NOP, 64'd4);
        cyc(1, 1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0, 1, 0);
        cyc(1, 0, 0, 1, 0, 1, 0);
        cyc(1, 1, 0, 1, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);

        // Redirect and response in the same WAIT cycle: one NOP, no DRAIN
        mem_lat  = 1;
        mem_word = 32'h3333_3333;
        push(NOP, 64'd4);
        cyc(1, 1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);

        // Reset in WAIT: late response lands in IDLE and is ignored
        mem_lat  = 2;
        mem_word = 32'h4444_4444;
        cyc(1, 1, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("fetch_cnt after reset", fetch_cnt, 64'd0);
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 1);

        // Counter wrap from all-ones on the next delivery
        mem_word = 32'h5555_5555;
        push(32'h5555_5555, 64'd0);
        cyc(1, 1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1, 0);
        force dut.fetch_cnt_q = ONES;
        #2;
        release dut.fetch_cnt_q;
        chk("forced fetch_cnt", fetch_cnt, ONES);
        cyc(1, 0, 0, 0, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);

        repeat (2) @(negedge clk);
        #2;
        chk("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_ctrl.md
IFU_FETCH_CTRL -- requirements
Module: ifu_fetch_ctrl

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rstn  in  1  reset, synchronous, active-low.
REQ-003 pc  in  64  current fetch PC from the fetch stage.
REQ-004 jump_en  in  1  redirect request, level; held by the requester until update=1.
REQ-005 be_stall  in  1  backend cannot accept a fetched instruction this cycle.
REQ-006 imem_req_valid  out  1  instruction-memory request valid.
REQ-007 imem_req_addr  out  64  request address; always equals pc.
REQ-008 imem_req_ready  in  1  memory accepts the request; handshake when valid&ready.
REQ-009 imem_rsp_valid  in  1  response valid; exactly one response per accepted request, at least one cycle after acceptance; always consumed.
REQ-010 imem_rsp_data  in  32  response instruction word.
REQ-011 instr  out  32  instruction delivered to the fetch stage; meaningful only when update=1.
REQ-012 update  out  1  one-cycle advance pulse for the fetch stage.
REQ-013 busy  out  1  high when state is WAIT or DRAIN.
REQ-014 fetch_cnt  out  64  count of memory instructions delivered with update=1 and jump_en=0.

Function
REQ-015 States: IDLE, REQ, WAIT, HOLD, DRAIN; at most one outstanding memory request.
REQ-016 IDLE: imem_req_valid=0; next state is REQ unconditionally.
REQ-017 REQ: imem_req_valid = !jump_en (combinational); on handshake -> WAIT.
REQ-018 REQ with jump_en=1: update=1, instr=32'h00000013, no handshake, stay REQ.
REQ-019 WAIT, rsp_valid=1, jump_en=0, be_stall=0: update=1, instr=rsp_data, fetch_cnt+1, -> REQ.
REQ-020 WAIT, rsp_valid=1, jump_en=0, be_stall=1: capture rsp_data into a 32-bit buffer, update=0, -> HOLD.
REQ-021 WAIT, rsp_valid=1, jump_en=1: update=1, instr=NOP, response discarded, -> REQ.
REQ-022 WAIT, rsp_valid=0, jump_en=1: update=1, instr=NOP, -> DRAIN.
REQ-023 WAIT, rsp_valid=0, jump_en=0: hold state, update=0.
REQ-024 HOLD, jump_en=0, be_stall=0: update=1, instr=buffer, fetch_cnt+1, -> REQ.
REQ-025 HOLD, jump_en=1: update=1, instr=NOP, buffer discarded, -> REQ.
REQ-026 HOLD, jump_en=0, be_stall=1: stay HOLD; buffer unchanged.
REQ-027 DRAIN: imem_req_valid=0, update=0; jump_en ignored; on rsp_valid discard data, -> REQ.
REQ-028 jump_en has priority over be_stall in every state.
REQ-029 update is never high on two consecutive cycles; never high in IDLE or DRAIN.
REQ-030 instr=32'h00000013 whenever update=0.
REQ-031 fetch_cnt wraps from 2^64-1 to 0; no saturation.
REQ-032 Fetch latency with zero-wait memory: handshake at cycle N, response at N+1, update at N+1, next request at N+2.

Reset
REQ-033 While rstn=0 at a clock edge: state<=IDLE, buffer<=0, fetch_cnt<=0.
REQ-034 While state=IDLE: imem_req_valid=0, update=0, busy=0, instr=NOP.
REQ-035 Reset during WAIT/DRAIN abandons the outstanding request; responses arriving in IDLE are ignored; the memory side is reset in the same cycle.

Verification
REQ-036 Reset release, req_ready=1, 1-cycle memory returning 0x00000093 -> IDLE one cycle, then update every 2 cycles with instr=0x00000093; fetch_cnt=1,2,3...
REQ-037 Response while be_stall=1 for 3 cycles -> HOLD, no update for 3 cycles, update on the first cycle be_stall=0, instr=buffered word; fetch_cnt+1.
REQ-038 jump_en in WAIT, response 4 cycles later -> update with NOP immediately, DRAIN, response discarded, new request at pc after the response; fetch_cnt unchanged.
REQ-039 jump_en and rsp_valid same cycle in WAIT -> single update, instr=NOP, next state REQ, no DRAIN.
REQ-040 jump_en in REQ with req_ready=1 -> imem_req_valid=0, no handshake, update=1 with NOP.
REQ-041 fetch_cnt forced to 2^64-1, one delivered instruction -> fetch_cnt=0.
